// File: rtl/sdram_burst_master.sv
// Burst master for the HPS f2h SDRAM Avalon-MM port: splits read/write commands into
// bursts of at most MAX_BURST words, buffering read data in a credit-checked FIFO.
module sdram_burst_master #(
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [29:0] cmd_address,
  input  logic [7:0]  cmd_length,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_byteenable,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [29:0] avm_address,
  output logic [7:0]  avm_burstcount,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SumW = CntW + 9;
  localparam logic [7:0]      MaxBc  = 8'(MAX_BURST);
  localparam logic [SumW-1:0] DepthS = SumW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdDrain, StWrBurst} state_e;

  state_e            state_q, state_d;
  logic [29:0]       addr_q, addr_d;
  logic [7:0]        rem_q, rem_d;
  logic [7:0]        bc_q, bc_d;
  logic [7:0]        beat_q, beat_d;
  logic [CntW-1:0]   out_q, out_d;
  logic              done_q, done_d;

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mem_q [2**PtrW];

  logic              cmd_fire;
  logic              rd_accept;
  logic              wr_accept;
  logic              push;
  logic              pop;
  logic              room_ok;
  logic [SumW-1:0]   room_sum;
  logic [7:0]        rem_after;
  logic [29:0]       addr_after;

  function automatic logic [7:0] clip_bc(input logic [7:0] n);
    return (n > MaxBc) ? MaxBc : n;
  endfunction

  assign cmd_ready  = (state_q == StIdle) && !done_q;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rem_after  = rem_q - bc_q;
  assign addr_after = addr_q + 30'(bc_q);

  // Words already buffered plus words in flight can only shrink while a request waits,
  // so once avm_read rises it stays high until accepted.
  assign room_sum  = SumW'(cnt_q) + SumW'(out_q) + SumW'(bc_q);
  assign room_ok   = room_sum <= DepthS;

  assign avm_read       = (state_q == StRdIssue) && room_ok;
  assign avm_write      = (state_q == StWrBurst) && wr_valid;
  assign wr_ready       = (state_q == StWrBurst) && !avm_waitrequest;
  assign avm_address    = addr_q;
  assign avm_burstcount = bc_q;
  assign avm_writedata  = wr_data;
  assign avm_byteenable = wr_byteenable;
  assign done           = done_q;

  assign rd_accept = avm_read && !avm_waitrequest;
  assign wr_accept = avm_write && !avm_waitrequest;

  // Beats with nothing outstanding belong to a command abandoned by reset.
  assign push     = avm_readdatavalid && (out_q != '0);
  assign rd_valid = (cnt_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    out_d = out_q;
    if (rd_accept) out_d = out_d + CntW'(bc_q);
    if (push)      out_d = out_d - CntW'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push) cnt_d = cnt_d + CntW'(1);
    if (pop)  cnt_d = cnt_d - CntW'(1);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bc_d    = bc_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          addr_d = cmd_address;
          rem_d  = cmd_length;
          bc_d   = clip_bc(cmd_length);
          beat_d = '0;
          if (cmd_length == 8'd0) begin
            done_d = 1'b1;
          end else if (cmd_write) begin
            state_d = StWrBurst;
          end else begin
            state_d = StRdIssue;
          end
        end
      end
      StRdIssue: begin
        if (rd_accept) begin
          addr_d = addr_after;
          rem_d  = rem_after;
          bc_d   = clip_bc(rem_after);
          if (rem_after == 8'd0) state_d = StRdDrain;
        end
      end
      StRdDrain: begin
        if (out_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StWrBurst: begin
        if (wr_accept) begin
          if (beat_q + 8'd1 == bc_q) begin
            beat_d = '0;
            addr_d = addr_after;
            rem_d  = rem_after;
            bc_d   = clip_bc(rem_after);
            if (rem_after == 8'd0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      bc_q    <= '0;
      beat_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      bc_q    <= bc_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end

endmodule
